alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand/result width.
REQ-002 Parameter OP_WIDTH, 4, ALU operation code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_op  input  OP_WIDTH  requester 0 ALU operation code.
REQ-007 req0_a / req0_b  input  DATA_WIDTH each  requester 0 operands A, B.
REQ-008 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-009 req1_valid, req1_op, req1_a, req1_b, req1_ready  same directions/widths/meanings for requester 1.
REQ-010 alu_op  output  OP_WIDTH  operation driven to the shared ALU.
REQ-011 alu_a / alu_b  output  DATA_WIDTH each  operands driven to the shared ALU.
REQ-012 alu_result  input  DATA_WIDTH  shared ALU result, combinational from alu_op/alu_a/alu_b.
REQ-013 alu_zero  input  1  shared ALU zero flag.
REQ-014 resp0_valid / resp1_valid  output  1 each  one-cycle pulse: response for requester 0/1.
REQ-015 resp_result  output  DATA_WIDTH  captured ALU result.
REQ-016 resp_zero  output  1  captured ALU zero flag.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-019 IDLE: if any reqN_valid, grant one requester; on the same edge register its op/a/b into alu_op/alu_a/alu_b, record grant owner, go to EXEC; else stay IDLE.
REQ-020 reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester; never both high in one cycle.
REQ-021 Transfer SHALL occur only on reqN_valid && reqN_ready; requesters hold valid and payload stable until accepted.
REQ-022 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not served last wins.
REQ-023 last_grant register SHALL update only on acceptance.
REQ-024 EXEC: alu_op/alu_a/alu_b held stable; on the edge, register alu_result into resp_result and alu_zero into resp_zero; go to RESP.
REQ-025 RESP: assert exactly the owner's respN_valid for this one cycle; go to IDLE unconditionally.
REQ-026 Latency: accept in cycle N -> respN_valid high in cycle N+2; new acceptance earliest in cycle N+3 (one op per 3 cycles).
REQ-027 resp_result/resp_zero SHALL hold their value until the next EXEC capture.
REQ-028 alu_op/alu_a/alu_b SHALL hold last issued values outside EXEC (no toggling in IDLE).
REQ-029 Op codes SHALL pass unchecked; undefined codes return whatever the ALU returns (0 for the shared ALU default).
REQ-030 No requests accepted while busy; valid raised during EXEC/RESP waits for IDLE.
REQ-031 A requester deasserting valid before ready SHALL be ignored without side effects.

Reset
REQ-032 reset high on a clock edge SHALL force state IDLE regardless of current state.
REQ-033 Reset values: alu_op/alu_a/alu_b = 0, resp_result = 0, resp_zero = 0, resp0_valid = resp1_valid = 0, busy = 0.
REQ-034 last_grant resets to requester 1, so requester 0 wins the first contested arbitration.
REQ-035 Reset in EXEC or RESP SHALL abandon the operation: no respN_valid pulse follows.
REQ-036 reqN_ready SHALL be 0 in every cycle reset is high.

Verification
REQ-037 req0 ADD (op 0011) a=5 b=7, accepted cycle N -> resp0_valid in N+2, resp_result=12, resp_zero=0, resp1_valid=0.
REQ-038 req1 SUB (op 0111) a=9 b=9 -> resp1_valid in N+2, resp_result=0, resp_zero=1.
REQ-039 Post-reset, both valid and held -> grant order req0, req1, req0 on successive acceptances 3 cycles apart; ready never simultaneous.
REQ-040 req0 LUI (op 0010) b=0x00001234 -> resp_result=0x12340000; busy high exactly in cycles N+1 and N+2.
REQ-041 Reset pulsed while EXEC -> no resp pulse, state IDLE, all outputs at reset values next cycle.
REQ-042 req1 valid raised during req0's EXEC -> req1_ready low until IDLE, then accepted; result correct.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared combinational ALU.
// One operation is in flight at a time: accept (IDLE) -> execute (EXEC) -> respond (RESP).
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [OP_WIDTH-1:0]   req0_op,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [OP_WIDTH-1:0]   req1_op,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic                  req1_ready,
   output logic [OP_WIDTH-1:0]   alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  resp0_valid,
   output logic                  resp1_valid,
   output logic [DATA_WIDTH-1:0] resp_result,
   output logic                  resp_zero,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q;  // requester served most recently
   logic                  owner_q;       // requester owning the in-flight operation
   logic [OP_WIDTH-1:0]   alu_op_q;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
   logic [DATA_WIDTH-1:0] resp_result_q;
   logic                  resp_zero_q;
   logic                  grant0, grant1;
   logic                  accept0, accept1;

   // Next-state, round-robin grant and handshake/response decode
   always_comb begin
      state_d     = state_q;
      grant0      = 1'b0;
      grant1      = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0_valid && req1_valid) begin
               // Contested: the requester not served last wins
               grant0 = last_grant_q;
               grant1 = !last_grant_q;
            end else begin
               grant0 = req0_valid;
               grant1 = req1_valid;
            end
            req0_ready = grant0 && !reset;
            req1_ready = grant1 && !reset;
            if (grant0 || grant1) state_d = StExec;
         end
         StExec: state_d = StResp;
         StResp: begin
            // Reset in this cycle abandons the response
            resp0_valid = !owner_q && !reset;
            resp1_valid = owner_q && !reset;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign accept0 = req0_valid && req0_ready;
   assign accept1 = req1_valid && req1_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Issue registers on acceptance, result capture at the end of EXEC
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q  <= 1'b1;
         owner_q       <= 1'b0;
         alu_op_q      <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         resp_result_q <= '0;
         resp_zero_q   <= 1'b0;
      end else begin
         if (accept0) begin
            alu_op_q     <= req0_op;
            alu_a_q      <= req0_a;
            alu_b_q      <= req0_b;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
         end else if (accept1) begin
            alu_op_q     <= req1_op;
            alu_a_q      <= req1_a;
            alu_b_q      <= req1_b;
            owner_q      <= 1'b1;
            last_grant_q <= 1'b1;
         end
         if (state_q == StExec) begin
            resp_result_q <= alu_result;
            resp_zero_q   <= alu_zero;
         end
      end
   end

   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign resp_result = resp_result_q;
   assign resp_zero   = resp_zero_q;
   assign busy        = (state_q != StIdle);

endmodule
